// File: rtl/mem_stage_dual_if.sv
// EX/MEM-to-WB bundle of the dual-issue MEM stage: both lanes' M inputs, data-memory port and W outputs.
// MisalignW exists only when MISALIGN_TRAP_EN is defined.
interface mem_stage_dual_if #(
  parameter int DMEM_AW = 10
);
  logic               FlushW_0, FlushW_1;
  logic               RegWriteM_0, RegWriteM_1;
  logic [1:0]         ResultSrcM_0, ResultSrcM_1;
  logic [2:0]         MemWriteM_0, MemWriteM_1;
  logic [2:0]         MemReadM_0, MemReadM_1;
  logic [31:0]        AluResultM_0, alu_outM_1;
  logic [4:0]         RdM_0, RdM_1;
  logic [31:0]        PcPlus4M_0, PcPlus4M_1;
  logic [31:0]        WriteDataM_0, WriteDataM_1;
  logic               StallM;
  logic               dmem_en;
  logic               dmem_we;
  logic [3:0]         dmem_wstrb;
  logic [DMEM_AW-1:0] dmem_addr;
  logic [31:0]        dmem_wdata;
  logic [31:0]        dmem_rdata;
  logic               RegWriteW_0, RegWriteW_1;
  logic [1:0]         ResultSrcW_0, ResultSrcW_1;
  logic [4:0]         RdW_0, RdW_1;
  logic [31:0]        PcPlus4W_0, PcPlus4W_1;
  logic [31:0]        AluResultW_0, AluResultW_1;
  logic [31:0]        ReadDataW_0, ReadDataW_1;
`ifdef MISALIGN_TRAP_EN
  logic [1:0]         MisalignW;
`endif

  // master: EX/MEM register plus data memory; slave: the MEM stage itself
  modport master (
    output FlushW_0, FlushW_1, RegWriteM_0, RegWriteM_1, ResultSrcM_0, ResultSrcM_1,
           MemWriteM_0, MemWriteM_1, MemReadM_0, MemReadM_1, AluResultM_0, alu_outM_1,
           RdM_0, RdM_1, PcPlus4M_0, PcPlus4M_1, WriteDataM_0, WriteDataM_1, dmem_rdata,
    input  StallM, dmem_en, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata,
           RegWriteW_0, RegWriteW_1, ResultSrcW_0, ResultSrcW_1, RdW_0, RdW_1,
           PcPlus4W_0, PcPlus4W_1, AluResultW_0, AluResultW_1, ReadDataW_0, ReadDataW_1
`ifdef MISALIGN_TRAP_EN
    , input MisalignW
`endif
  );

  modport slave (
    input  FlushW_0, FlushW_1, RegWriteM_0, RegWriteM_1, ResultSrcM_0, ResultSrcM_1,
           MemWriteM_0, MemWriteM_1, MemReadM_0, MemReadM_1, AluResultM_0, alu_outM_1,
           RdM_0, RdM_1, PcPlus4M_0, PcPlus4M_1, WriteDataM_0, WriteDataM_1, dmem_rdata,
    output StallM, dmem_en, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata,
           RegWriteW_0, RegWriteW_1, ResultSrcW_0, ResultSrcW_1, RdW_0, RdW_1,
           PcPlus4W_0, PcPlus4W_1, AluResultW_0, AluResultW_1, ReadDataW_0, ReadDataW_1
`ifdef MISALIGN_TRAP_EN
    , output MisalignW
`endif
  );
endinterface

// File: rtl/mem_stage_dual.sv
// MEM stage + MEM/WB register for both lanes; serializes dual memory ops on one dmem port (lane 0 first).
// Optional MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
module mem_stage_dual #(
  parameter int DMEM_AW = 10
) (
  input logic             clk,
  input logic             rst_n,
  mem_stage_dual_if.slave bus
);

  typedef enum logic {ONE, SECOND} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_NONE} size_e;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdat;
  } wlane_t;

  function automatic logic is_store(input logic [2:0] w);
    return (w == 3'b001) || (w == 3'b010) || (w == 3'b011);
  endfunction

  function automatic logic is_load(input logic [2:0] r);
    return (r >= 3'b001) && (r <= 3'b101);
  endfunction

  function automatic size_e op_size(input logic [2:0] w, input logic [2:0] r);
    if (w == 3'b001 || r == 3'b001 || r == 3'b100) return SZ_B;
    if (w == 3'b010 || r == 3'b010 || r == 3'b101) return SZ_H;
    if (w == 3'b011 || r == 3'b011)                return SZ_W;
    return SZ_NONE;
  endfunction

  // Effective byte offset: halves align to a[1], words to 0
  function automatic logic [1:0] eff_off(input size_e s, input logic [1:0] a);
    case (s)
      SZ_B:    return a;
      SZ_H:    return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  function automatic logic misaligned(input size_e s, input logic [1:0] a);
    case (s)
      SZ_H:    return a[0];
      SZ_W:    return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction
`endif

  function automatic logic [3:0] store_strb(input logic [2:0] w, input logic [1:0] off);
    case (w)
      3'b001:  return 4'b0001 << off;
      3'b010:  return 4'b0011 << off;
      3'b011:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] w, input logic [31:0] d);
    case (w)
      3'b001:  return {4{d[7:0]}};
      3'b010:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] r, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (r)
      3'b001:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b010:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      3'b011:  return rd;
      default: return 32'h0;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        hold_q, hold_d;
  wlane_t [1:0]       w_q, w_d;
  logic [1:0][2:0]    mw, mr;
  logic [1:0][31:0]   addr, wd;
  logic [1:0]         memop;
  logic               sel, act, cap, stall, en, we;
  size_e              sz;
  logic [1:0]         off;
  logic [31:0]        rfmt, rd0, rd1;
  logic [3:0]         strb;
  logic [31:0]        wdata;
  logic [DMEM_AW-1:0] daddr;
`ifdef MISALIGN_TRAP_EN
  logic [1:0]         mis, mis_q, mis_d;
`endif

  assign mw   = {bus.MemWriteM_1, bus.MemWriteM_0};
  assign mr   = {bus.MemReadM_1, bus.MemReadM_0};
  assign addr = {bus.alu_outM_1, bus.AluResultM_0};
  assign wd   = {bus.WriteDataM_1, bus.WriteDataM_0};

  always_comb begin
    for (int i = 0; i < 2; i++) memop[i] = is_store(mw[i]) | is_load(mr[i]);
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    for (int i = 0; i < 2; i++) mis[i] = misaligned(op_size(mw[i], mr[i]), addr[i][1:0]);
  end
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    stall   = 1'b0;
    sel     = 1'b0;
    act     = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      ONE: begin
        sel = ~memop[0];
        act = memop[0] | memop[1];
        if (memop[0] & memop[1]) begin
          stall   = 1'b1;
          state_d = SECOND;
        end else begin
          cap = 1'b1;
        end
      end
      SECOND: begin
        // Flushing lane 1 cancels its access; lane 0's was already performed
        sel     = 1'b1;
        act     = memop[1] & ~bus.FlushW_1;
        cap     = 1'b1;
        state_d = ONE;
      end
    endcase

    sz    = op_size(mw[sel], mr[sel]);
    off   = eff_off(sz, addr[sel][1:0]);
    en    = act;
    rfmt  = load_fmt(mr[sel], off, bus.dmem_rdata);
`ifdef MISALIGN_TRAP_EN
    if (mis[sel]) begin
      if (is_store(mw[sel])) en = 1'b0;
      rfmt = 32'h0;
    end
`endif
    we    = en & is_store(mw[sel]);
    strb  = we ? store_strb(mw[sel], off) : 4'b0000;
    wdata = we ? store_data(mw[sel], wd[sel]) : 32'h0;
    daddr = act ? addr[sel][DMEM_AW+1:2] : '0;

    if (stall) hold_d = rfmt;
    rd0 = (state_q == SECOND) ? hold_q : (sel ? 32'h0 : rfmt);
    rd1 = sel ? rfmt : 32'h0;

    w_d = w_q;
    if (cap) begin
      w_d[0] = bus.FlushW_0 ? '0 : {bus.RegWriteM_0, bus.ResultSrcM_0, bus.RdM_0,
                                    bus.PcPlus4M_0, bus.AluResultM_0, rd0};
      w_d[1] = bus.FlushW_1 ? '0 : {bus.RegWriteM_1, bus.ResultSrcM_1, bus.RdM_1,
                                    bus.PcPlus4M_1, bus.alu_outM_1, rd1};
    end
`ifdef MISALIGN_TRAP_EN
    mis_d = mis_q;
    if (cap) mis_d = mis & ~{bus.FlushW_1, bus.FlushW_0};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ONE;
      hold_q  <= '0;
      w_q     <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      w_q     <= w_d;
`ifdef MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // Upstream is never held while the stage sits in reset
  assign bus.StallM       = stall & rst_n;
  assign bus.dmem_en      = en;
  assign bus.dmem_we      = we;
  assign bus.dmem_wstrb   = strb;
  assign bus.dmem_addr    = daddr;
  assign bus.dmem_wdata   = wdata;
  assign bus.RegWriteW_0  = w_q[0].rw;
  assign bus.ResultSrcW_0 = w_q[0].rs;
  assign bus.RdW_0        = w_q[0].rd;
  assign bus.PcPlus4W_0   = w_q[0].pc;
  assign bus.AluResultW_0 = w_q[0].alu;
  assign bus.ReadDataW_0  = w_q[0].rdat;
  assign bus.RegWriteW_1  = w_q[1].rw;
  assign bus.ResultSrcW_1 = w_q[1].rs;
  assign bus.RdW_1        = w_q[1].rd;
  assign bus.PcPlus4W_1   = w_q[1].pc;
  assign bus.AluResultW_1 = w_q[1].alu;
  assign bus.ReadDataW_1  = w_q[1].rdat;
`ifdef MISALIGN_TRAP_EN
  assign bus.MisalignW    = mis_q;
`endif

endmodule

// File: tb/tb_mem_stage_dual.sv
// Scoreboard bench for mem_stage_dual: directed dual-lane vectors, W outputs checked by a separate monitor.
module tb_mem_stage_dual;

  localparam logic [2:0] NONE = 3'b000, SB = 3'b001, SH = 3'b010, SW = 3'b011;
  localparam logic [2:0] LB = 3'b001, LH = 3'b010, LW = 3'b011, LBU = 3'b100, LHU = 3'b101;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [2:0]  mw;
    logic [2:0]  mr;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
  } lane_in_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdat;
  } wlane_t;

  typedef struct packed {
    wlane_t     l0;
    wlane_t     l1;
    logic [1:0] mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_dual_if #(.DMEM_AW(10)) bus ();
  mem_stage_dual #(.DMEM_AW(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [31:0] mem [0:1023];
  assign bus.dmem_rdata = mem[bus.dmem_addr];
  always @(posedge clk) begin
    if (bus.dmem_en && bus.dmem_we)
      for (int b = 0; b < 4; b++)
        if (bus.dmem_wstrb[b]) mem[bus.dmem_addr][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  logic m_valid = 1'b0;
  logic vld_n;

  int          obs_stalls;
  logic        obs_en_first, obs_en_acc;
  logic [3:0]  obs_strb_first;
  logic [31:0] obs_wdata_first;
  logic [9:0]  obs_addr_first;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic lane_in_t mk(input logic rw, input logic [1:0] rs, input logic [2:0] mw,
                                  input logic [2:0] mr, input logic [4:0] rd, input logic [31:0] pc,
                                  input logic [31:0] alu, input logic [31:0] wd);
    return {rw, rs, mw, mr, rd, pc, alu, wd};
  endfunction

  function automatic wlane_t wexp(input lane_in_t l, input logic fl, input logic [31:0] rdat);
    wlane_t w;
    w = {l.rw, l.rs, l.rd, l.pc, l.alu, rdat};
    return fl ? '0 : w;
  endfunction

  task automatic drive(input lane_in_t a, input lane_in_t b);
    bus.RegWriteM_0 = a.rw;  bus.ResultSrcM_0 = a.rs; bus.MemWriteM_0 = a.mw; bus.MemReadM_0 = a.mr;
    bus.RdM_0 = a.rd; bus.PcPlus4M_0 = a.pc; bus.AluResultM_0 = a.alu; bus.WriteDataM_0 = a.wd;
    bus.RegWriteM_1 = b.rw;  bus.ResultSrcM_1 = b.rs; bus.MemWriteM_1 = b.mw; bus.MemReadM_1 = b.mr;
    bus.RdM_1 = b.rd; bus.PcPlus4M_1 = b.pc; bus.alu_outM_1 = b.alu; bus.WriteDataM_1 = b.wd;
  endtask

  // f1 is raised only in the accepting cycle (the SECOND cycle when the pair conflicts)
  task automatic issue(input lane_in_t a, input lane_in_t b, input logic f0, input logic f1,
                       input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] emis);
    exp_t e;
    @(posedge clk); #1;
    drive(a, b);
    bus.FlushW_0 = f0;
    bus.FlushW_1 = 1'b0;
    m_valid = 1'b1;
    e.l0 = wexp(a, f0, e0);
    e.l1 = wexp(b, f1, e1);
    e.mis = emis & ~{f1, f0};
    sbq.push_back(e);
    #1;
    obs_stalls = 0;
    obs_en_first = bus.dmem_en;
    obs_strb_first = bus.dmem_wstrb;
    obs_wdata_first = bus.dmem_wdata;
    obs_addr_first = bus.dmem_addr;
    for (int i = 0; i < 4; i++) begin
      if (!bus.StallM) break;
      obs_stalls++;
      @(posedge clk); #2;
    end
    if (bus.StallM) chk("stall_bound", 1, 0);
    bus.FlushW_1 = f1;
    #1;
    obs_en_acc = bus.dmem_en;
    @(negedge clk);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    drive('0, '0);
    bus.FlushW_0 = 1'b0;
    bus.FlushW_1 = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic chk_w_zero(input string tag);
    chk({tag, "_w0"}, {bus.RegWriteW_0, bus.ResultSrcW_0, bus.RdW_0, bus.PcPlus4W_0,
                       bus.AluResultW_0, bus.ReadDataW_0}, 0);
    chk({tag, "_w1"}, {bus.RegWriteW_1, bus.ResultSrcW_1, bus.RdW_1, bus.PcPlus4W_1,
                       bus.AluResultW_1, bus.ReadDataW_1}, 0);
    chk({tag, "_stall"}, bus.StallM, 0);
  endtask

  // Monitor: any M op accepted at an edge must appear on the W outputs after that edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      vld_n = m_valid && !bus.StallM && rst_n;
      @(posedge clk); #2;
      if (vld_n) begin
        if (sbq.size() == 0) begin
          chk("unexpected_w", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("w_lane0", {bus.RegWriteW_0, bus.ResultSrcW_0, bus.RdW_0, bus.PcPlus4W_0,
                          bus.AluResultW_0, bus.ReadDataW_0}, e.l0);
          chk("w_lane1", {bus.RegWriteW_1, bus.ResultSrcW_1, bus.RdW_1, bus.PcPlus4W_1,
                          bus.AluResultW_1, bus.ReadDataW_1}, e.l1);
`ifdef MISALIGN_TRAP_EN
          chk("misalign_w", bus.MisalignW, e.mis);
`endif
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  lane_in_t nop0, nop1;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]  = 32'h8001_1234;
    mem[12] = 32'h4433_2280;
    nop0 = mk(0, 2'd0, NONE, NONE, 5'd0, 32'h0000_0110, 32'h0, 32'h0);
    nop1 = mk(0, 2'd0, NONE, NONE, 5'd0, 32'h0000_0114, 32'h0, 32'h0);
    drive('0, '0);
    bus.FlushW_0 = 1'b0;
    bus.FlushW_1 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_w_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // SW 0xDEADBEEF @0x10 with an ALU op on lane 1
    issue(mk(0, 2'd0, SW, NONE, 5'd0, 32'h104, 32'h10, 32'hDEAD_BEEF),
          mk(1, 2'd0, NONE, NONE, 5'd5, 32'h108, 32'h1234, 32'h0), 0, 0, 32'h0, 32'h0, 2'b00);
    chk("sw_stall", obs_stalls, 0);
    chk("sw_strb", obs_strb_first, 4'b1111);
    chk("sw_addr", obs_addr_first, 10'd4);
    chk("sw_wdata", obs_wdata_first, 32'hDEAD_BEEF);
    chk("sw_en", obs_en_acc, 1);

    issue(mk(1, 2'd1, NONE, LW, 5'd6, 32'h10C, 32'h10, 32'h0), nop1, 0, 0,
          32'hDEAD_BEEF, 32'h0, 2'b00);
    chk("lw_stall", obs_stalls, 0);

    // Conflict: store then load of the same byte sees the new data
    issue(mk(0, 2'd0, SB, NONE, 5'd0, 32'h200, 32'h21, 32'h1234_567F),
          mk(1, 2'd1, NONE, LB, 5'd7, 32'h204, 32'h21, 32'h0), 0, 0, 32'h0, 32'h7F, 2'b00);
    chk("sb_lb_stall", obs_stalls, 1);
    chk("sb_strb", obs_strb_first, 4'b0010);
    chk("sb_wdata", obs_wdata_first, 32'h7F7F_7F7F);

    issue(mk(1, 2'd1, NONE, LB, 5'd8, 32'h300, 32'h30, 32'h0),
          mk(1, 2'd1, NONE, LBU, 5'd9, 32'h304, 32'h30, 32'h0), 0, 0,
          32'hFFFF_FF80, 32'h0000_0080, 2'b00);
    chk("lb_lbu_stall", obs_stalls, 1);

    issue(mk(1, 2'd1, NONE, LH, 5'd10, 32'h308, 32'h2, 32'h0), nop1, 0, 0,
          32'hFFFF_8001, 32'h0, 2'b00);

    // Lane 1 alone owns the port; lane 0 flushed
    issue(mk(1, 2'd0, NONE, NONE, 5'd11, 32'h30C, 32'h55, 32'h0),
          mk(1, 2'd1, NONE, LHU, 5'd12, 32'h310, 32'h2, 32'h0), 1, 0, 32'h0, 32'h0000_8001, 2'b00);
    chk("lhu_stall", obs_stalls, 0);

    issue(nop0, mk(0, 2'd0, SH, NONE, 5'd0, 32'h400, 32'h42, 32'h0000_ABCD), 0, 0,
          32'h0, 32'h0, 2'b00);
    chk("sh_strb", obs_strb_first, 4'b1100);
    chk("sh_wdata", obs_wdata_first, 32'hABCD_ABCD);
    chk("sh_addr", obs_addr_first, 10'd16);

    issue(mk(1, 2'd1, NONE, LW, 5'd13, 32'h404, 32'h40, 32'h0), nop1, 0, 0,
          32'hABCD_0000, 32'h0, 2'b00);

    // Dual loads with lane 1 flushed in SECOND
    issue(mk(1, 2'd1, NONE, LW, 5'd14, 32'h500, 32'h10, 32'h0),
          mk(1, 2'd1, NONE, LW, 5'd15, 32'h504, 32'h30, 32'h0), 0, 1,
          32'hDEAD_BEEF, 32'h0, 2'b00);
    chk("flush_stall", obs_stalls, 1);
    chk("flush_en", obs_en_acc, 0);

    issue(mk(1, 2'd1, NONE, LB, 5'd16, 32'h508, 32'h31, 32'h0), nop1, 0, 0,
          32'h0000_0022, 32'h0, 2'b00);
    chk("after_flush_stall", obs_stalls, 0);

    // Async reset while in SECOND
    idle();
    @(posedge clk); #1;
    drive(mk(1, 2'd1, NONE, LW, 5'd1, 32'h600, 32'h10, 32'h0),
          mk(1, 2'd1, NONE, LW, 5'd2, 32'h604, 32'h30, 32'h0));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_w_zero("midsecond_rst");
    @(posedge clk); #1;
    drive('0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(mk(1, 2'd1, NONE, LW, 5'd3, 32'h608, 32'h10, 32'h0), nop1, 0, 0,
          32'hDEAD_BEEF, 32'h0, 2'b00);
    chk("post_rst_stall", obs_stalls, 0);

    // Unaligned word store
`ifdef MISALIGN_TRAP_EN
    issue(mk(0, 2'd0, SW, NONE, 5'd0, 32'h700, 32'h13, 32'hCAFE_F00D), nop1, 0, 0,
          32'h0, 32'h0, 2'b01);
    chk("sw13_en", obs_en_first, 0);
    issue(mk(1, 2'd1, NONE, LW, 5'd4, 32'h704, 32'h10, 32'h0), nop1, 0, 0,
          32'hDEAD_BEEF, 32'h0, 2'b00);
`else
    issue(mk(0, 2'd0, SW, NONE, 5'd0, 32'h700, 32'h13, 32'hCAFE_F00D), nop1, 0, 0,
          32'h0, 32'h0, 2'b00);
    chk("sw13_en", obs_en_first, 1);
    chk("sw13_addr", obs_addr_first, 10'd4);
    chk("sw13_strb", obs_strb_first, 4'b1111);
    issue(mk(1, 2'd1, NONE, LW, 5'd4, 32'h704, 32'h10, 32'h0), nop1, 0, 0,
          32'hCAFE_F00D, 32'h0, 2'b00);
`endif

    idle();
    repeat (3) @(posedge clk);
    #3;
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
